// File: rtl/eth_tx_arbiter_pkg.sv
// Shared constants and FSM encoding for the Ethernet transmit arbiter.
// The sender and top level reuse the same frame-size constants.
package eth_tx_arbiter_pkg;

    localparam int ETH_MIN_LEN = 60;
    localparam int ETH_MAX_LEN = 1514;
    localparam int ETH_IFG     = 12;
    localparam int ETH_CNT_W   = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_PAD   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_t;

endpackage

// File: rtl/eth_tx_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes
// to the requester that did not own the previous frame.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) gnt = last_owner ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the RGMII sender: pads runts,
// truncates/drains over-length frames and enforces the inter-frame gap.
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int MIN_LEN    = ETH_MIN_LEN,
    parameter int MAX_LEN    = ETH_MAX_LEN,
    parameter int IFG_CYCLES = ETH_IFG,
    parameter int CNT_W      = ETH_CNT_W
) (
    input  logic       ETH_RXCLK,
    input  logic       RST,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic [1:0] grant,
    output logic       trunc_pulse
);

    localparam int GAP_W = $clog2(IFG_CYCLES + 1);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEN);
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(IFG_CYCLES - 1);

    arb_state_t       state;
    logic             owner;
    logic             last_owner;
    logic [CNT_W-1:0] byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [1:0]       gnt;

    logic [7:0]       own_data;
    logic             own_valid, own_last, own_ready;
    logic [CNT_W-1:0] cnt_next;
    logic             hit_min, hit_max;

    rr_arb2 u_rr (
        .req        ({s1_valid, s0_valid}),
        .last_owner (last_owner),
        .gnt        (gnt)
    );

    assign own_data  = owner ? s1_data  : s0_data;
    assign own_valid = owner ? s1_valid : s0_valid;
    assign own_last  = owner ? s1_last  : s0_last;
    assign cnt_next  = byte_cnt + 1'b1;
    assign hit_min   = cnt_next >= MIN_C;
    assign hit_max   = cnt_next == MAX_C;

    // Only the owner ever sees ready; DRAIN swallows bytes unconditionally.
    assign own_ready = (state == ST_SEND) ? m_ready : (state == ST_DRAIN);
    assign s0_ready  = own_ready & ~owner;
    assign s1_ready  = own_ready &  owner;

    always_comb begin
        m_data      = 8'h00;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        trunc_pulse = 1'b0;
        case (state)
            ST_SEND: begin
                m_data      = own_data;
                m_valid     = own_valid;
                m_last      = (own_last & hit_min) | hit_max;
                trunc_pulse = own_valid & m_ready & hit_max & ~own_last;
            end
            ST_PAD: begin
                m_valid = 1'b1;
                m_last  = (cnt_next == MIN_C);
            end
            default: ;
        endcase
    end

    always_ff @(posedge ETH_RXCLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            grant      <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner <= gnt[1];
                        grant <= gnt;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (own_valid && m_ready) begin
                        byte_cnt <= cnt_next;
                        if (own_last && hit_min) begin
                            state   <= ST_GAP;
                            grant   <= 2'b00;
                            gap_cnt <= '0;
                        end else if (own_last) begin
                            state <= ST_PAD;
                        end else if (hit_max) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_PAD: begin
                    if (m_ready) begin
                        byte_cnt <= cnt_next;
                        if (cnt_next == MIN_C) begin
                            state   <= ST_GAP;
                            grant   <= 2'b00;
                            gap_cnt <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (own_valid && own_last) begin
                        state   <= ST_GAP;
                        grant   <= 2'b00;
                        gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_END) begin
                        state      <= ST_IDLE;
                        last_owner <= owner;
                        byte_cnt   <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench: frame-level reference model (expected byte stream per
// frame) driven by a table of frame cases plus arbitration and reset sequences.
module tb_eth_tx_arbiter;

    localparam int MIN = 60;
    localparam int MAX = 1514;
    localparam int IFG = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s0_data, s1_data, m_data;
    logic       s0_valid, s0_last, s0_ready;
    logic       s1_valid, s1_last, s1_ready;
    logic       m_valid, m_last, m_ready;
    logic [1:0] grant;
    logic       trunc_pulse;

    always #4 clk = ~clk;

    eth_tx_arbiter dut (
        .ETH_RXCLK   (clk),
        .RST         (rst),
        .s0_data     (s0_data),
        .s0_valid    (s0_valid),
        .s0_last     (s0_last),
        .s0_ready    (s0_ready),
        .s1_data     (s1_data),
        .s1_valid    (s1_valid),
        .s1_last     (s1_last),
        .s1_ready    (s1_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .grant       (grant),
        .trunc_pulse (trunc_pulse)
    );

    int n_checks = 0;
    int n_err    = 0;

    // source-side queues (bytes still to offer, frame lengths not yet started)
    logic [7:0] sq0[$], sq1[$];
    int         lq0[$], lq1[$];
    int         rem0, rem1;
    // reference model output: expected bytes, frame lengths and owners
    logic [7:0] exp_d[$];
    int         exp_len[$], exp_src[$];
    int         exp_trunc;
    // monitor state
    logic [7:0] got[$];
    int         gbad, idle_run, trunc_seen, last_len;
    bit         after_last;

    typedef struct {
        int src;
        int len;
        int val_pct;
        int rdy_pct;
        int exp_out;
        int exp_trunc;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame-level model: keep the first MAX bytes, zero-pad up to MIN.
    task automatic add_frame(input int src, input int len);
        logic [7:0] b;
        int n_out;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            if (src == 0) sq0.push_back(b); else sq1.push_back(b);
            if (i < MAX) exp_d.push_back(b);
        end
        for (int i = len; i < MIN; i++) exp_d.push_back(8'h00);
        if (src == 0) lq0.push_back(len); else lq1.push_back(len);
        n_out = (len > MAX) ? MAX : ((len < MIN) ? MIN : len);
        exp_len.push_back(n_out);
        exp_src.push_back(src);
        if (len > MAX) exp_trunc++;
    endtask

    task automatic finish_frame();
        int L, mism;
        last_len = got.size();
        if (exp_len.size() == 0) begin
            chk("unexpected_frame_len", got.size(), 0);
        end else begin
            L = exp_len.pop_front();
            void'(exp_src.pop_front());
            mism = 0;
            for (int i = 0; i < L; i++) begin
                if (exp_d.size() > 0) begin
                    if (i >= got.size() || got[i] != exp_d[0]) mism++;
                    void'(exp_d.pop_front());
                end
            end
            chk("frame_len", got.size(), L);
            chk("frame_data_mismatches", mism, 0);
            chk("frame_grant_errors", gbad, 0);
        end
        got.delete();
        gbad = 0;
    endtask

    task automatic clear_model();
        sq0.delete(); sq1.delete(); lq0.delete(); lq1.delete();
        exp_d.delete(); exp_len.delete(); exp_src.delete(); got.delete();
        rem0 = 0; rem1 = 0; gbad = 0; after_last = 0; idle_run = 1000;
        exp_trunc = 0; trunc_seen = 0;
    endtask

    // Drive both sources and m_ready each cycle; sample just after negedge.
    task automatic run(input int budget, input int val_pct, input int rdy_pct,
                       input int stop_after);
        int nbytes = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (rem0 == 0 && lq0.size() > 0) rem0 = lq0.pop_front();
            if (rem1 == 0 && lq1.size() > 0) rem1 = lq1.pop_front();
            s0_valid = (rem0 > 0) && ($urandom_range(99) < val_pct);
            s0_data  = (rem0 > 0) ? sq0[0] : 8'h00;
            s0_last  = (rem0 == 1);
            s1_valid = (rem1 > 0) && ($urandom_range(99) < val_pct);
            s1_data  = (rem1 > 0) ? sq1[0] : 8'h00;
            s1_last  = (rem1 == 1);
            m_ready  = ($urandom_range(99) < rdy_pct);
            #1;
            if (s0_valid && s0_ready) begin void'(sq0.pop_front()); rem0--; end
            if (s1_valid && s1_ready) begin void'(sq1.pop_front()); rem1--; end
            if (trunc_pulse) trunc_seen++;
            if (m_valid) begin
                if (after_last) begin
                    chk("ifg_idle_ok", int'(idle_run >= IFG), 1);
                    after_last = 0;
                end
                idle_run = 0;
            end else begin
                idle_run++;
            end
            if (m_valid && m_ready) begin
                if (exp_src.size() == 0 || grant != ((exp_src[0] == 0) ? 2'b01 : 2'b10))
                    gbad++;
                got.push_back(m_data);
                nbytes++;
                if (m_last) begin
                    finish_frame();
                    after_last = 1;
                end
            end
            if (stop_after > 0 && nbytes == stop_after) return;
            if (stop_after == 0 && rem0 == 0 && rem1 == 0 && lq0.size() == 0 &&
                lq1.size() == 0 && exp_len.size() == 0) begin
                @(negedge clk);
                s0_valid = 0; s1_valid = 0; s0_last = 0; s1_last = 0;
                return;
            end
        end
        chk("run_timeout", 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; s0_valid = 0; s1_valid = 0; s0_last = 0; s1_last = 0;
        s0_data = 0; s1_data = 0; m_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        clear_model();
    endtask

    vec_t vecs[11];

    initial begin
        int tr0;
        vecs[0]  = '{0,  100, 100, 100,  100, 0};
        vecs[1]  = '{1,   20, 100, 100,   60, 0};
        vecs[2]  = '{0, 1600, 100, 100, 1514, 1};
        vecs[3]  = '{0,   60, 100, 100,   60, 0};
        vecs[4]  = '{1,   59, 100, 100,   60, 0};
        vecs[5]  = '{0, 1514, 100, 100, 1514, 0};
        vecs[6]  = '{1, 1515, 100, 100, 1514, 1};
        vecs[7]  = '{0,    1, 100,  50,   60, 0};
        vecs[8]  = '{0,  200,  60,  70,  200, 0};
        vecs[9]  = '{1,   30,  50,  50,   60, 0};
        vecs[10] = '{0, 1520,  70,  60, 1514, 1};

        rst = 1; s0_valid = 0; s1_valid = 0; s0_last = 0; s1_last = 0;
        s0_data = 0; s1_data = 0; m_ready = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_s0_ready", s0_ready, 0);
        chk("rst_s1_ready", s1_ready, 0);
        chk("rst_grant", grant, 0);
        chk("rst_trunc", trunc_pulse, 0);
        @(negedge clk);
        rst = 0;

        foreach (vecs[k]) begin
            tr0 = trunc_seen;
            last_len = -1;
            add_frame(vecs[k].src, vecs[k].len);
            run(8000, vecs[k].val_pct, vecs[k].rdy_pct, 0);
            chk($sformatf("vec%0d_out_len", k), last_len, vecs[k].exp_out);
            chk($sformatf("vec%0d_trunc", k), trunc_seen - tr0, vecs[k].exp_trunc);
        end

        // Simultaneous requesters after reset: s0, s1, s0, s1.
        do_reset();
        add_frame(0, 61); add_frame(1, 63); add_frame(0, 62); add_frame(1, 64);
        run(4000, 100, 100, 0);
        chk("arb_frames_left", exp_len.size(), 0);

        // Reset in the middle of a frame, then clean restart with s0 first.
        do_reset();
        add_frame(0, 100);
        run(2000, 100, 100, 30);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_grant", grant, 0);
        @(negedge clk);
        rst = 0; s0_valid = 0; s1_valid = 0;
        clear_model();
        add_frame(0, 60); add_frame(1, 70);
        run(4000, 100, 100, 0);
        chk("post_rst_frames_left", exp_len.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
